// File: rtl/contador_iteraciones.sv
// contador_iteraciones: iteration counter with a start/busy/done handshake.
// Counts down from n_i to 0 or up from 0 to n_i, in one-shot or auto-reload
// mode, with a one-cycle terminal-count pulse and a saturating round counter.
// The limit, direction and mode are captured at start, so the controlling FSM
// may change n_i while a count is in progress.
// Optional build macro: CONTADOR_PRESCALER_EN adds presc_i and a prescaler that
// divides the enabled cycles before each step.

module contador_iteraciones #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ROUND_W = 4,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               en_i,
    input  logic [WIDTH-1:0]   n_i,
    input  logic               dir_i,
    input  logic               auto_reload_i,
`ifdef CONTADOR_PRESCALER_EN
    input  logic [PRESC_W-1:0] presc_i,
`endif
    output logic [WIDTH-1:0]   count_o,
    output logic               busy_o,
    output logic               tc_o,
    output logic               done_o,
    output logic [ROUND_W-1:0] rounds_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   lim_q, lim_d;
    logic               dir_q, dir_d;
    logic               ar_q, ar_d;
    logic               tc_q, tc_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d;

    logic [WIDTH-1:0]   init_val;
    logic [WIDTH-1:0]   term_val;
    logic               start_ok;
    logic               step_hit;

    // Start and terminal values follow the captured direction, not dir_i.
    assign init_val = dir_q ? '0 : lim_q;
    assign term_val = dir_q ? lim_q : '0;

    // A start is only honoured outside RUN; in RUN it is ignored.
    assign start_ok = start_i && (state_q != StRun);

`ifdef CONTADOR_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;

    // A step happens only on the enabled cycle where the prescaler reaches presc_i.
    assign step_hit = (presc_q == presc_i);

    // Prescaler next state: cleared on stop/start, advanced or wrapped on enabled RUN cycles.
    always_comb begin
        presc_d = presc_q;
        if (stop_i || start_ok) begin
            presc_d = '0;
        end else if ((state_q == StRun) && en_i) begin
            presc_d = step_hit ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic [PRESC_W-1:0] presc_lim;

    // No prescaler: a zero limit makes every enabled cycle a step.
    assign presc_lim = '0;
    assign step_hit  = ~|presc_lim;
`endif

    // Next-state logic; priority is stop, then start, then enable.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        lim_d    = lim_q;
        dir_d    = dir_q;
        ar_d     = ar_q;
        rounds_d = rounds_q;
        tc_d     = 1'b0;

        if (stop_i) begin
            // Abort keeps count and rounds visible; done clears via the state.
            state_d = StIdle;
        end else if (start_ok) begin
            lim_d    = n_i;
            dir_d    = dir_i;
            ar_d     = auto_reload_i;
            count_d  = dir_i ? '0 : n_i;
            rounds_d = '0;
            state_d  = StRun;
        end else if ((state_q == StRun) && en_i && step_hit) begin
            if (count_q == term_val) begin
                tc_d = 1'b1;
                if (ar_q) begin
                    count_d = init_val;
                    if (rounds_q != '1) begin
                        rounds_d = rounds_q + ROUND_W'(1);
                    end
                end else begin
                    // One-shot: count parks on the terminal value.
                    state_d = StDone;
                end
            end else if (dir_q) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            lim_q    <= '0;
            dir_q    <= 1'b0;
            ar_q     <= 1'b0;
            tc_q     <= 1'b0;
            rounds_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lim_q    <= lim_d;
            dir_q    <= dir_d;
            ar_q     <= ar_d;
            tc_q     <= tc_d;
            rounds_q <= rounds_d;
        end
    end

    // Outputs come straight from registers.
    assign count_o  = count_q;
    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign tc_o     = tc_q;
    assign rounds_o = rounds_q;

    // The count never leaves the range bounded by the captured limit.
    assert property (@(posedge clk) disable iff (rst) count_q <= lim_q);

    // A terminal pulse can only follow a cycle spent in RUN.
    assert property (@(posedge clk) disable iff (rst) tc_q |-> ($past(state_q) == StRun));

endmodule

// File: tb/tb_contador_iteraciones.sv
// tb_contador_iteraciones: table-driven bench for contador_iteraciones.
// Each record holds the inputs for one cycle and the outputs expected after
// that cycle's rising edge; expectations go through a scoreboard queue.

module tb_contador_iteraciones;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned PRESC_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               stop_i;
    logic               en_i;
    logic [WIDTH-1:0]   n_i;
    logic               dir_i;
    logic               auto_reload_i;
`ifdef CONTADOR_PRESCALER_EN
    logic [PRESC_W-1:0] presc_i;
`endif
    logic [WIDTH-1:0]   count_o;
    logic               busy_o;
    logic               tc_o;
    logic               done_o;
    logic [ROUND_W-1:0] rounds_o;

    typedef struct {
        logic [WIDTH-1:0]   count;
        logic               busy;
        logic               tc;
        logic               done;
        logic [ROUND_W-1:0] rounds;
    } exp_t;

    typedef struct {
        logic             rst;
        logic             start;
        logic             stop;
        logic             en;
        logic [WIDTH-1:0] n;
        logic             dir;
        logic             ar;
        exp_t             exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    contador_iteraciones #(
        .WIDTH  (WIDTH),
        .ROUND_W(ROUND_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .en_i         (en_i),
        .n_i          (n_i),
        .dir_i        (dir_i),
        .auto_reload_i(auto_reload_i),
`ifdef CONTADOR_PRESCALER_EN
        .presc_i      (presc_i),
`endif
        .count_o      (count_o),
        .busy_o       (busy_o),
        .tc_o         (tc_o),
        .done_o       (done_o),
        .rounds_o     (rounds_o)
    );

    always #5 clk = ~clk;

    // Build one record: inputs first, then expected count, busy, tc, done, rounds.
    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic e,
                                input logic [WIDTH-1:0] n, input logic d, input logic a,
                                input logic [WIDTH-1:0] c, input logic b, input logic t,
                                input logic dn, input logic [ROUND_W-1:0] rn);
        vec_t v;
        v.rst        = r;
        v.start      = s;
        v.stop       = p;
        v.en         = e;
        v.n          = n;
        v.dir        = d;
        v.ar         = a;
        v.exp.count  = c;
        v.exp.busy   = b;
        v.exp.tc     = t;
        v.exp.done   = dn;
        v.exp.rounds = rn;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic cycle(input vec_t v, input string tag);
        exp_t x;
        rst           = v.rst;
        start_i       = v.start;
        stop_i        = v.stop;
        en_i          = v.en;
        n_i           = v.n;
        dir_i         = v.dir;
        auto_reload_i = v.ar;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        checks++;
        if (count_o !== x.count || busy_o !== x.busy || tc_o !== x.tc ||
            done_o !== x.done || rounds_o !== x.rounds) begin
            errors++;
            $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b rounds=%0d, want count=%0d busy=%b tc=%b done=%b rounds=%0d",
                     tag, count_o, busy_o, tc_o, done_o, rounds_o,
                     x.count, x.busy, x.tc, x.done, x.rounds);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        en_i          = 1'b0;
        n_i           = '0;
        dir_i         = 1'b0;
        auto_reload_i = 1'b0;
`ifdef CONTADOR_PRESCALER_EN
        presc_i       = '0;
`endif

        //                rst st sp en  n dir ar  cnt bsy tc dn rnd
        // Reset state.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        // One-shot down from 3; en in the start cycle is ignored; one held cycle.
        vecs.push_back(mk(0, 1, 0, 1, 3, 0, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 1, 0));
        // Up auto-reload to 2, started from DONE, nine enabled cycles.
        vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  2, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  0, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  1, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  2, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  0, 1, 1, 0, 3));
        // Stop from RUN: rounds held, no tc.
        vecs.push_back(mk(0, 0, 1, 1, 2, 1, 1,  0, 0, 0, 0, 3));
        // n=0 one-shot: terminal on first enabled cycle.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0));
        // Start and stop together from DONE: stop wins.
        vecs.push_back(mk(0, 1, 1, 1, 7, 1, 1,  0, 0, 0, 0, 0));
        // Stop at count 4 holds the count; later enables do nothing.
        vecs.push_back(mk(0, 1, 0, 0, 6, 0, 0,  6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 6, 0, 0,  4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 0,  4, 0, 0, 0, 0));
        // Up to 5; start in RUN ignored and n_i/dir_i/auto_reload_i changes have no effect.
        vecs.push_back(mk(0, 1, 0, 0, 5, 1, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 9, 0, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 1,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  5, 0, 1, 1, 0));
        // Back-to-back: done high one cycle, then restart held in that cycle.
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0));
        // Reset mid-count: n=5 down, two enables, reset discards everything.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 5, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], $sformatf("tbl[%0d]", i));
        end

        // n=255 down: 256 enabled cycles to done.
        cycle(mk(0, 1, 0, 0, 255, 0, 0, 255, 1, 0, 0, 0), "n255_start");
        for (int i = 1; i <= 255; i++) begin
            cycle(mk(0, 0, 0, 1, 255, 0, 0, WIDTH'(255 - i), 1, 0, 0, 0),
                  $sformatf("n255_step%0d", i));
        end
        cycle(mk(0, 0, 0, 1, 255, 0, 0, 0, 0, 1, 1, 0), "n255_done");

        // 20 reloads with n=0 up: every enabled cycle is terminal; rounds saturate at 15.
        cycle(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0), "sat_start");
        for (int i = 1; i <= 20; i++) begin
            cycle(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, ROUND_W'((i > 15) ? 15 : i)),
                  $sformatf("sat_round%0d", i));
        end
        cycle(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 15), "sat_stop");

`ifdef CONTADOR_PRESCALER_EN
        // presc_i=2, n=1 down: count changes every 3 enabled cycles, tc on the 6th.
        presc_i = 4'd2;
        cycle(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), "presc_start");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0), "presc_en1");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0), "presc_en2");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "presc_en3");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "presc_en4");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "presc_en5");
        cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0), "presc_en6");
        presc_i = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
